// File: rtl/if_prefetch_q_pkg.sv
// Shared constants and helpers for the instruction-fetch prefetch queue.
// Default widths mirror the cpu-wide instruction and address properties.
package if_prefetch_q_pkg;

    localparam int unsigned CPU_INST_WIDTH = 32;
    localparam int unsigned CPU_ADDR_WIDTH = 32;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned occ_width(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_flush.sv
// Generic DEPTH x WIDTH synchronous FIFO with a synchronous clear and an occupancy count.
// Push is ignored when full and pop when empty; clear overrides both.
module sync_fifo_flush
    import if_prefetch_q_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           _rst,
    input  logic                           clr,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_push = push & (count_q != CW'(DEPTH));
    assign do_pop  = pop & (count_q != '0);

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: reads are qualified by a non-zero count upstream.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_prefetch_q.sv
// Instruction-fetch front end: credit-limited requests into a flushable prefetch queue,
// valid/ready toward decode, and redirect on taken jumps.
module if_prefetch_q
    import if_prefetch_q_pkg::*;
#(
    parameter int unsigned INST_WIDTH = CPU_INST_WIDTH,
    parameter int unsigned ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic                           clk,
    input  logic                           _rst,
    input  logic                           jump_en,
    input  logic [ADDR_WIDTH-1:0]          jump_addr,
    output logic                           inst_req,
    output logic [ADDR_WIDTH-1:0]          inst_addr,
    input  logic [INST_WIDTH-1:0]          inst_in,
    output logic                           out_valid,
    output logic [INST_WIDTH-1:0]          out_inst,
    output logic [ADDR_WIDTH-1:0]          out_pc,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned CW = occ_width(DEPTH);
    localparam int unsigned EW = INST_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, req_pc_q;
    logic                  inflight_q;
    logic [CW-1:0]         fifo_count;
    logic [EW-1:0]         fifo_rdata;
    logic                  credit_ok, push, pop;

    // Same-cycle pops are not credited, so a granted request always has a free slot.
    assign credit_ok = ({1'b0, fifo_count} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
    assign inst_req  = _rst & ~jump_en & credit_ok;
    assign inst_addr = fetch_pc_q;

    // A flush kills the response returning in the same cycle.
    assign push = inflight_q & ~jump_en;
    assign pop  = out_valid & out_ready & ~jump_en;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else if (jump_en) begin
            fetch_pc_q <= jump_addr;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inst_req;
            if (inst_req) begin
                fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(PC_STEP);
                req_pc_q   <= fetch_pc_q;
            end
        end
    end

    sync_fifo_flush #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        ._rst  (_rst),
        .clr   (jump_en),
        .push  (push),
        .wdata ({inst_in, req_pc_q}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign count     = fifo_count;
    assign out_valid = (fifo_count != '0);
    assign out_inst  = out_valid ? fifo_rdata[EW-1:ADDR_WIDTH] : '0;
    assign out_pc    = out_valid ? fifo_rdata[ADDR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_if_prefetch_q.sv
// Self-checking bench for if_prefetch_q: randomized traffic against a queue-based model
// plus spec-level checks on delivered PC order, flush and reset behaviour.
module tb_if_prefetch_q;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          _rst = 1'b0;
    logic          jump_en = 1'b0;
    logic [31:0]   jump_addr = '0;
    logic          inst_req;
    logic [31:0]   inst_addr;
    logic [31:0]   inst_in = '0;
    logic          out_valid;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;

    // Reference model: queue of PCs awaiting decode plus the outstanding request.
    logic [31:0] mq[$];
    bit          m_infl;
    logic [31:0] m_req_pc, m_fetch_pc;
    // Expected outputs for the current cycle.
    bit          e_req, e_valid;
    logic [31:0] e_addr, e_pc, e_inst;
    int          e_count;
    // Memory model state.
    bit          mem_pend;
    logic [31:0] mem_addr;

    if_prefetch_q #(
        .INST_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0),
        .PC_STEP    (4)
    ) dut (
        .clk       (clk),
        ._rst      (_rst),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .inst_req  (inst_req),
        .inst_addr (inst_addr),
        .inst_in   (inst_in),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_infl     = 1'b0;
        m_req_pc   = '0;
        m_fetch_pc = '0;
        mem_pend   = 1'b0;
    endtask

    // Drive inputs (called just after an edge) and compute expectations at mid-cycle.
    task automatic settle(input bit j, input logic [31:0] ja, input bit rdy);
        jump_en   = j;
        jump_addr = ja;
        out_ready = rdy;
        #4;
        e_req   = !j && ((mq.size() + int'(m_infl)) < DEPTH);
        e_addr  = m_fetch_pc;
        e_valid = mq.size() > 0;
        e_count = mq.size();
        e_pc    = e_valid ? mq[0] : 32'h0;
        e_inst  = e_valid ? (mq[0] ^ KEY) : 32'h0;
    endtask

    // Apply the clock edge to both the model and the DUT.
    task automatic advance();
        if (jump_en) begin
            mq.delete();
            m_infl     = 1'b0;
            m_fetch_pc = jump_addr;
        end else begin
            if (e_valid && out_ready) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_req_pc);
            if (e_req) begin
                m_req_pc   = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            m_infl = e_req;
        end
        mem_pend = inst_req;
        mem_addr = inst_addr;
        @(posedge clk);
        #1;
        inst_in = mem_pend ? (mem_addr ^ KEY) : $urandom;
    endtask

    task automatic do_reset(input int n);
        _rst = 1'b0;
        jump_en = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        #1;
        _rst = 1'b1;
    endtask

    task automatic test_reset();
        _rst = 1'b0;
        jump_en = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({inst_req, out_valid, count, inst_addr, out_pc, out_inst} !== {1'b0, 1'b0, CW'(0), 96'h0}) begin
                failures++;
                $display("FAIL reset_hold req=%0b valid=%0b count=%0d addr=%h pc=%h inst=%h required 0 0 0 0 0 0",
                         inst_req, out_valid, count, inst_addr, out_pc, out_inst);
            end
        end
        _rst = 1'b1;
        settle(1'b0, 32'h0, 1'b1);
        checks++;
        if ({inst_req, inst_addr} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_first_req req=%0b addr=%h required 1 00000000", inst_req, inst_addr);
        end
        advance();
    endtask

    task automatic test_streaming();
        logic [31:0] nxt = 32'h0;
        int          first_valid = -1;
        for (int i = 0; i < 14; i++) begin
            settle(1'b0, 32'h0, 1'b1);
            checks++;
            if ({inst_req, inst_addr, out_valid, count} !== {e_req, e_addr, e_valid, CW'(e_count)}) begin
                failures++;
                $display("FAIL stream_ctrl req=%0b addr=%h valid=%0b count=%0d required %0b %h %0b %0d",
                         inst_req, inst_addr, out_valid, count, e_req, e_addr, e_valid, e_count);
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = i;
                checks++;
                if ({out_pc, out_inst} !== {nxt, nxt ^ KEY}) begin
                    failures++;
                    $display("FAIL stream_data pc=%h inst=%h required %h %h", out_pc, out_inst, nxt, nxt ^ KEY);
                end
                nxt = nxt + 32'd4;
            end
            advance();
        end
        // First request was issued in the cycle before this loop, so valid appears at index 1.
        checks++;
        if (first_valid != 1 || nxt != 32'd52) begin
            failures++;
            $display("FAIL stream_rate first_valid=%0d next_pc=%h required 1 00000034", first_valid, nxt);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            settle(1'b0, 32'h0, 1'b0);
            checks++;
            if ({inst_req, out_valid, count} !== {e_req, e_valid, CW'(e_count)}) begin
                failures++;
                $display("FAIL bp_fill req=%0b valid=%0b count=%0d required %0b %0b %0d",
                         inst_req, out_valid, count, e_req, e_valid, e_count);
            end
            advance();
        end
        settle(1'b0, 32'h0, 1'b0);
        checks++;
        if ({count, inst_req} !== {CW'(4), 1'b0}) begin
            failures++;
            $display("FAIL bp_saturate count=%0d req=%0b required 4 0", count, inst_req);
        end
        advance();
        for (int i = 0; i < 8; i++) begin
            settle(1'b0, 32'h0, 1'b1);
            if (out_valid) got.push_back(out_pc);
            advance();
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= got.size() || got[k] !== 32'(k * 4)) begin
                failures++;
                $display("FAIL bp_order idx=%0d pc=%h required %h", k,
                         (k < got.size()) ? got[k] : 32'hx, 32'(k * 4));
            end
        end
    endtask

    task automatic test_flush_inflight();
        logic [31:0] got[$];
        int          guard = 0;
        do_reset(1);
        settle(1'b0, 32'h0, 1'b0);
        while (!(mq.size() == 3 && m_infl) && guard < 12) begin
            advance();
            settle(1'b0, 32'h0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 12 || count !== CW'(3)) begin
            failures++;
            $display("FAIL flush_setup count=%0d guard=%0d required 3", count, guard);
        end
        settle(1'b1, 32'h100, 1'b1);
        checks++;
        if (inst_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_req req=%0b required 0", inst_req);
        end
        advance();
        settle(1'b0, 32'h0, 1'b1);
        checks++;
        if ({count, out_valid, inst_req, inst_addr} !== {CW'(0), 1'b0, 1'b1, 32'h100}) begin
            failures++;
            $display("FAIL flush_after count=%0d valid=%0b req=%0b addr=%h required 0 0 1 00000100",
                     count, out_valid, inst_req, inst_addr);
        end
        for (int i = 0; i < 6; i++) begin
            if (out_valid) got.push_back(out_pc);
            advance();
            settle(1'b0, 32'h0, 1'b1);
        end
        advance();
        checks++;
        if (got.size() < 2 || got[0] !== 32'h100 || got[1] !== 32'h104) begin
            failures++;
            $display("FAIL flush_target n=%0d first=%h second=%h required 00000100 00000104",
                     got.size(), (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx);
        end
    endtask

    task automatic test_flush_pop_b2b();
        logic [31:0] got[$];
        int          guard = 0;
        bit          saw_200 = 1'b0;
        do_reset(1);
        settle(1'b0, 32'h0, 1'b0);
        while (mq.size() != DEPTH && guard < 12) begin
            advance();
            settle(1'b0, 32'h0, 1'b0);
            guard++;
        end
        advance();
        settle(1'b1, 32'h200, 1'b1);
        checks++;
        if ({count, out_valid, inst_req} !== {CW'(4), 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_full count=%0d valid=%0b req=%0b required 4 1 0", count, out_valid, inst_req);
        end
        advance();
        settle(1'b1, 32'h300, 1'b1);
        advance();
        for (int i = 0; i < 8; i++) begin
            settle(1'b0, 32'h0, 1'b1);
            checks++;
            if ({inst_req, inst_addr, out_valid, count} !== {e_req, e_addr, e_valid, CW'(e_count)}) begin
                failures++;
                $display("FAIL b2b_ctrl req=%0b addr=%h valid=%0b count=%0d required %0b %h %0b %0d",
                         inst_req, inst_addr, out_valid, count, e_req, e_addr, e_valid, e_count);
            end
            if (out_valid) begin
                got.push_back(out_pc);
                if (out_pc[31:8] == 24'h2) saw_200 = 1'b1;
            end
            advance();
        end
        checks++;
        if (saw_200 || got.size() < 2 || got[0] !== 32'h300 || got[1] !== 32'h304) begin
            failures++;
            $display("FAIL b2b_target saw_200=%0b n=%0d first=%h required 0 >=2 00000300", saw_200,
                     got.size(), (got.size() > 0) ? got[0] : 32'hx);
        end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] nxt = 32'h0;
        bit          rdy;
        do_reset(1);
        for (int i = 0; i < 10 * DEPTH; i++) begin
            rdy = 1'($urandom_range(0, 1));
            settle(1'b0, 32'h0, rdy);
            checks++;
            if ({inst_req, inst_addr, out_valid, count} !== {e_req, e_addr, e_valid, CW'(e_count)}) begin
                failures++;
                $display("FAIL wrap_ctrl req=%0b addr=%h valid=%0b count=%0d required %0b %h %0b %0d",
                         inst_req, inst_addr, out_valid, count, e_req, e_addr, e_valid, e_count);
            end
            if (out_valid && rdy) begin
                checks++;
                if ({out_pc, out_inst} !== {nxt, nxt ^ KEY}) begin
                    failures++;
                    $display("FAIL wrap_data pc=%h inst=%h required %h %h", out_pc, out_inst, nxt, nxt ^ KEY);
                end
                nxt = nxt + 32'd4;
            end
            advance();
        end
        checks++;
        if (nxt < 32'(3 * DEPTH * 4)) begin
            failures++;
            $display("FAIL wrap_progress next_pc=%h required >= %h", nxt, 32'(3 * DEPTH * 4));
        end
        // Reset between edges must take effect without a clock.
        jump_en   = 1'b0;
        out_ready = 1'b0;
        #2;
        _rst = 1'b0;
        #1;
        checks++;
        if ({inst_req, out_valid, count, inst_addr, out_pc, out_inst} !== {1'b0, 1'b0, CW'(0), 96'h0}) begin
            failures++;
            $display("FAIL async_reset req=%0b valid=%0b count=%0d addr=%h pc=%h inst=%h required 0 0 0 0 0 0",
                     inst_req, out_valid, count, inst_addr, out_pc, out_inst);
        end
        do_reset(2);
        settle(1'b0, 32'h0, 1'b1);
        checks++;
        if ({inst_req, inst_addr, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_restart req=%0b addr=%h valid=%0b required 1 00000000 0",
                     inst_req, inst_addr, out_valid);
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_inflight();
        test_flush_pop_b2b();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d required completion", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_prefetch_q.md
Name: if_prefetch_q

Overview:
- Parametrised instruction-fetch front end with a prefetch queue.
- Sits between instruction memory and the decode stage. It generalises the single-register fetch stage to a DEPTH-entry queue.
- Adds a valid/ready handshake toward decode, credit-limited fetch requests, and flush/redirect on taken jumps.
- An in-flight memory response is discarded when a flush lands on it.

Parameters:
- INST_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, fetch address / PC width.
- DEPTH, 4, queue entries; power of two, ≥2. Full single-issue throughput requires ≥3.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  clock, rising edge.
- _rst  in  1  asynchronous, active-low reset.
- jump_en  in  1  redirect request from execute: flushes the block and restarts fetch.
- jump_addr  in  ADDR_WIDTH  redirect target.
- inst_req  out  1  fetch request to instruction memory.
- inst_addr  out  ADDR_WIDTH  fetch address, valid when inst_req=1.
- inst_in  in  INST_WIDTH  memory data; fixed 1-cycle latency after the request cycle.
- out_valid  out  1  queue head valid toward decode.
- out_inst  out  INST_WIDTH  head instruction.
- out_pc  out  ADDR_WIDTH  PC of the head instruction.
- out_ready  in  1  decode accepts the head; low means stall.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset _rst is asynchronous and active-low.
- Reset values (while _rst=0):
  - fetch_pc=RESET_PC, so inst_addr=RESET_PC.
  - inst_req=0, out_valid=0, count=0.
  - out_inst=0, out_pc=0.
  - in-flight flag=0, read/write pointers=0.
- Reset mid-operation: all state returns to reset values immediately. Queued and in-flight instructions are lost.
- Fetch issue:
  - Combinational: inst_req = _rst & ~jump_en & (count + inflight < DEPTH).
  - This uses the current count; a same-cycle pop is not credited. Overflow is therefore impossible by construction.
- On an issued request:
  - fetch_pc += PC_STEP, wrapping modulo 2^ADDR_WIDTH.
  - inflight<=1.
  - req_pc<=fetch_pc.
  - If no request is issued, inflight<=0.
- Response:
  - In the cycle after a request (inflight=1, no flush), {inst_in, req_pc} is written at the tail pointer.
  - Latency: request in cycle N, write at the end of N+1, out_valid=1 in N+2. There is no bypass path.
- Pop: when out_valid & out_ready, the head pointer advances at the clock edge.
  - out_inst/out_pc are driven from the head entry; they are don't-care when out_valid=0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers: log2(DEPTH) bits, wrapping naturally. Full = (count==DEPTH); empty = (count==0).
- Flush (jump_en=1), highest priority:
  - Next edge: count<=0, pointers<=0, inflight<=0, fetch_pc<=jump_addr.
  - Any response arriving in the flush cycle is not written.
  - No pop occurs, even if out_ready=1.
  - inst_req=0 in the flush cycle. The first request to jump_addr issues in the next cycle.
- Flush while full, flush while empty, and flush coincident with push or pop all follow the rule above.
- Back-to-back jump_en: each cycle re-targets, and the last target wins.
- The held head is stable while out_valid=1 & out_ready=0, unless a flush occurs.

Decomposition:
- INST_WIDTH/ADDR_WIDTH defaults come from the shared cpu property include; no new global constants.
- One sub-module, sync_fifo_flush: generic DEPTH×(INST_WIDTH+ADDR_WIDTH) FIFO.
  - Push, pop, synchronous clear, count output, same clk/_rst.
  - This block adds the fetch-PC register, credit logic, in-flight tracking and the response-kill path.

Test Plan:
- Reset: hold _rst=0 for 3 cycles with jump_en=0 → inst_req=0, out_valid=0, count=0, inst_addr=0. First cycle after release: inst_req=1, inst_addr=0.
- Streaming: out_ready=1, memory returns word=addr^0xA5A5_0000 → inst_req every cycle. out_pc sequence 0,4,8,… starting 2 cycles after the first request, one per cycle, with out_inst matching.
- Backpressure: DEPTH=4, out_ready=0 → count saturates at 4 and inst_req drops once count+inflight=4. Release out_ready → pcs 0,4,8,12,16 in order, no loss or duplicate.
- Flush with in-flight response: jump_en=1, jump_addr=0x100 in a cycle where inflight=1 and count=3 → next cycle count=0 and the stale response is not enqueued. Next out_pc=0x100, then 0x104.
- Flush coincident with pop on a full queue, then back-to-back jumps to 0x200 then 0x300 → only 0x300 is fetched and delivered; no out_valid for 0x200.
- Wrap and reset: run 3×DEPTH pushes/pops with random out_ready, then assert _rst mid-stream asynchronously (between edges) → outputs take reset values without waiting for an edge. Ordering is correct across pointer wrap.
